scr1_mul_arb: RTL

- Controller and two-port arbiter in front of the shared iterative 33x33 signed multiplier `scr1_pipe_mul`.
- Accepts RV32M multiply requests (MUL/MULH/MULHSU/MULHU) from two requesters: port 0 is the EXU, port 1 is the auxiliary/accelerator path.
- Builds sign-extended 33-bit operands, sequences the multiplier's valid/ready/done handshake and selects the result half.
- Returns a tagged response to the winning requester; one operation is in flight at a time.

---
 rtl/scr1_mul_arb_pkg.sv | 37 +++
 rtl/scr1_rr_arb2.sv | 41 ++++
 rtl/scr1_mul_arb.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/scr1_mul_arb_pkg.sv
// Shared types for the two-port RV32M multiply front end: funct codes, FSM
// states and the funct -> operand-sign/result-half decode.
package scr1_mul_arb_pkg;

  typedef enum logic [1:0] {
    MUL_FUNCT_MUL    = 2'b00,
    MUL_FUNCT_MULH   = 2'b01,
    MUL_FUNCT_MULHSU = 2'b10,
    MUL_FUNCT_MULHU  = 2'b11
  } type_mul_funct_e;

  typedef enum logic [1:0] {
    MUL_ARB_IDLE,
    MUL_ARB_ISSUE,
    MUL_ARB_BUSY,
    MUL_ARB_RESP
  } type_mul_arb_fsm_e;

  typedef struct packed {
    logic sign1_en;
    logic sign2_en;
    logic sel_hi;
  } type_mul_ctrl_s;

  // sign*_en says whether bit 31 of the operand is propagated into bit 32
  function automatic type_mul_ctrl_s mul_funct_decode(input type_mul_funct_e funct);
    type_mul_ctrl_s ctrl;
    case (funct)
      MUL_FUNCT_MUL:    ctrl = '{sign1_en: 1'b0, sign2_en: 1'b0, sel_hi: 1'b0};
      MUL_FUNCT_MULH:   ctrl = '{sign1_en: 1'b1, sign2_en: 1'b1, sel_hi: 1'b1};
      MUL_FUNCT_MULHSU: ctrl = '{sign1_en: 1'b1, sign2_en: 1'b0, sel_hi: 1'b1};
      default:          ctrl = '{sign1_en: 1'b0, sign2_en: 1'b0, sel_hi: 1'b1};
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/scr1_rr_arb2.sv
// Two-input grant logic: round-robin against the last completed port, or
// fixed priority to port 0 when RR_EN is 0.
module scr1_rr_arb2 #(
  parameter bit RR_EN = 1'b1
)(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       upd_idx_i,
  output logic [1:0] gnt_o,
  output logic       gnt_idx_o
);

  logic last_q;

  // Reset to 1 so port 0 wins the first contested grant
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (upd_i) begin
      last_q <= upd_idx_i;
    end
  end

  always_comb begin
    gnt_idx_o = 1'b0;
    if (RR_EN) begin
      if (req_i == 2'b11) begin
        gnt_idx_o = ~last_q;
      end else begin
        gnt_idx_o = req_i[1];
      end
    end else begin
      gnt_idx_o = ~req_i[0];
    end
  end

  assign gnt_o = {req_i[1] & gnt_idx_o, req_i[0] & ~gnt_idx_o};

endmodule

// File: rtl/scr1_mul_arb.sv
// Two-port controller for the shared iterative 33x33 multiplier: arbitrates,
// builds signed operands, sequences the multiplier handshake, returns a tagged result.
module scr1_mul_arb
  import scr1_mul_arb_pkg::*;
#(
  parameter int unsigned TAG_W   = 4,
  parameter bit          RR_EN   = 1'b1,
  parameter int unsigned TIMEOUT = 32
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_funct,
  input  logic [31:0]      req0_op1,
  input  logic [31:0]      req0_op2,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_funct,
  input  logic [31:0]      req1_op1,
  input  logic [31:0]      req1_op2,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [31:0]      rsp0_data,
  output logic [TAG_W-1:0] rsp0_tag,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp1_data,
  output logic [TAG_W-1:0] rsp1_tag,
  output logic             rsp1_err,
  output logic             mul_valid_o,
  output logic [32:0]      mul_din1_o,
  output logic [32:0]      mul_din2_o,
  input  logic [31:0]      mul_hig_i,
  input  logic [31:0]      mul_low_i,
  input  logic             mul_rdy_i,
  output logic             mul_done_o,
  output logic             busy_o
);

  localparam int unsigned WDOG_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  type_mul_arb_fsm_e state_q;
  logic              gnt_idx_q;
  logic [TAG_W-1:0]  tag_q;
  logic [32:0]       din1_q;
  logic [32:0]       din2_q;
  logic              sel_hi_q;
  logic              mul_valid_q;
  logic              mul_done_q;
  logic              rsp_valid_q;
  logic              err_q;
  logic [31:0]       data_q;
  logic [WDOG_W-1:0] wdog_q;

  logic [1:0]        arb_req;
  logic [1:0]        arb_gnt;
  logic              arb_idx;
  logic              accept;
  logic              rsp_hs;
  logic [1:0]        acc_funct;
  logic [31:0]       acc_op1;
  logic [31:0]       acc_op2;
  logic [TAG_W-1:0]  acc_tag;
  type_mul_ctrl_s    acc_ctrl;
  logic [32:0]       din1_d;
  logic [32:0]       din2_d;
  logic [31:0]       res_d;

  // Requests are only looked at in IDLE, so ready is a single-cycle grant
  assign arb_req = (state_q == MUL_ARB_IDLE && !rst) ? {req1_valid, req0_valid} : 2'b00;

  scr1_rr_arb2 #(
    .RR_EN (RR_EN)
  ) i_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (arb_req),
    .upd_i     (rsp_hs),
    .upd_idx_i (gnt_idx_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx)
  );

  assign accept     = |arb_gnt;
  assign req0_ready = arb_gnt[0];
  assign req1_ready = arb_gnt[1];

  assign acc_funct = arb_idx ? req1_funct : req0_funct;
  assign acc_op1   = arb_idx ? req1_op1   : req0_op1;
  assign acc_op2   = arb_idx ? req1_op2   : req0_op2;
  assign acc_tag   = arb_idx ? req1_tag   : req0_tag;
  assign acc_ctrl  = mul_funct_decode(type_mul_funct_e'(acc_funct));
  assign din1_d    = {acc_ctrl.sign1_en & acc_op1[31], acc_op1};
  assign din2_d    = {acc_ctrl.sign2_en & acc_op2[31], acc_op2};
  assign res_d     = sel_hi_q ? mul_hig_i : mul_low_i;
  assign rsp_hs    = rsp_valid_q & (gnt_idx_q ? rsp1_ready : rsp0_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MUL_ARB_IDLE;
      gnt_idx_q   <= 1'b0;
      tag_q       <= '0;
      din1_q      <= '0;
      din2_q      <= '0;
      sel_hi_q    <= 1'b0;
      mul_valid_q <= 1'b0;
      mul_done_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      data_q      <= '0;
      wdog_q      <= '0;
    end else begin
      mul_valid_q <= 1'b0;
      mul_done_q  <= 1'b0;
      case (state_q)
        MUL_ARB_IDLE: begin
          if (accept) begin
            gnt_idx_q   <= arb_idx;
            tag_q       <= acc_tag;
            din1_q      <= din1_d;
            din2_q      <= din2_d;
            sel_hi_q    <= acc_ctrl.sel_hi;
            mul_valid_q <= 1'b1;
            state_q     <= MUL_ARB_ISSUE;
          end
        end
        MUL_ARB_ISSUE: begin
          wdog_q  <= '0;
          state_q <= MUL_ARB_BUSY;
        end
        // A result arriving on the expiry cycle still takes priority
        MUL_ARB_BUSY: begin
          if (mul_rdy_i) begin
            data_q      <= res_d;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            mul_done_q  <= 1'b1;
            state_q     <= MUL_ARB_RESP;
          end else if (wdog_q == WDOG_W'(TIMEOUT - 1)) begin
            data_q      <= '0;
            err_q       <= 1'b1;
            rsp_valid_q <= 1'b1;
            mul_done_q  <= 1'b1;
            state_q     <= MUL_ARB_RESP;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        MUL_ARB_RESP: begin
          if (rsp_hs) begin
            rsp_valid_q <= 1'b0;
            state_q     <= MUL_ARB_IDLE;
          end
        end
        default: state_q <= MUL_ARB_IDLE;
      endcase
    end
  end

  assign mul_valid_o = mul_valid_q;
  assign mul_done_o  = mul_done_q;
  assign mul_din1_o  = din1_q;
  assign mul_din2_o  = din2_q;
  assign busy_o      = (state_q != MUL_ARB_IDLE);

  assign rsp0_valid = rsp_valid_q & ~gnt_idx_q;
  assign rsp0_data  = rsp0_valid ? data_q : '0;
  assign rsp0_tag   = rsp0_valid ? tag_q : '0;
  assign rsp0_err   = rsp0_valid & err_q;
  assign rsp1_valid = rsp_valid_q & gnt_idx_q;
  assign rsp1_data  = rsp1_valid ? data_q : '0;
  assign rsp1_tag   = rsp1_valid ? tag_q : '0;
  assign rsp1_err   = rsp1_valid & err_q;

endmodule
